// File: rtl/led_blink_sequencer.sv
// Blink sequencer: runs cmd_count on/off LED cycles with durations measured in
// prescaled ticks, reporting completion with done and cancellation with aborted.
module led_blink_sequencer #(
    parameter int CLK_FREQ_KHz = 50000,
    parameter int TICK_FREQ_Hz = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_count,
    input  logic [15:0] cmd_on_ms,
    input  logic [15:0] cmd_off_ms,
    input  logic        abort,
    output logic        led,
    output logic        busy,
    output logic [7:0]  blinks_left,
    output logic        done,
    output logic        aborted
);

    localparam int TICK_DIV = (CLK_FREQ_KHz * 1000) / TICK_FREQ_Hz;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    if ((TICK_DIV < 1) || ((TICK_DIV * TICK_FREQ_Hz) != (CLK_FREQ_KHz * 1000))) begin : g_cfg_error
        $error("led_blink_sequencer: clock/tick ratio must be an exact integer >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [PW-1:0]  presc_r, presc_nxt_s;
    logic [15:0]    phase_r, phase_nxt_s;
    logic [15:0]    on_dur_r, on_dur_nxt_s;
    logic [15:0]    off_dur_r, off_dur_nxt_s;
    logic [15:0]    cur_dur_s;
    logic [7:0]     blinks_left_r, blinks_nxt_s;
    logic           led_r, led_nxt_s;
    logic           busy_r, busy_nxt_s;
    logic           ready_r, ready_nxt_s;
    logic           done_r, done_nxt_s;
    logic           aborted_r, aborted_nxt_s;
    logic           accept_s, tick_s, phase_end_s, last_blink_s;

    // Handshake, tick and phase-boundary decode shared by FSM and datapath.
    always_comb begin
        accept_s     = cmd_valid & ready_r;
        tick_s       = (state_r != ST_IDLE) && (presc_r == PRESC_MAX);
        last_blink_s = (blinks_left_r == 8'd1);
        if (state_r == ST_ON) begin
            cur_dur_s = on_dur_r;
        end else begin
            cur_dur_s = off_dur_r;
        end
        phase_end_s  = tick_s && (phase_r == (cur_dur_s - 16'd1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks a phase boundary in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cmd_count != 8'd0)) begin
                    state_nxt_s = ST_ON;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (phase_end_s) begin
                    state_nxt_s = ST_OFF;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_OFF: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (phase_end_s) begin
                    if (last_blink_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ON;
                    end
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values, all registered below.
    always_comb begin
        led_nxt_s     = (state_nxt_s == ST_ON);
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
        ready_nxt_s   = (state_nxt_s == ST_IDLE);
        done_nxt_s    = 1'b0;
        aborted_nxt_s = 1'b0;
        blinks_nxt_s  = blinks_left_r;
        presc_nxt_s   = presc_r;
        phase_nxt_s   = phase_r;
        on_dur_nxt_s  = on_dur_r;
        off_dur_nxt_s = off_dur_r;
        case (state_r)
            ST_IDLE: begin
                presc_nxt_s  = {PW{1'b0}};
                phase_nxt_s  = 16'd0;
                blinks_nxt_s = 8'd0;
                if (accept_s) begin
                    blinks_nxt_s  = cmd_count;
                    on_dur_nxt_s  = (cmd_on_ms == 16'd0) ? 16'd1 : cmd_on_ms;
                    off_dur_nxt_s = (cmd_off_ms == 16'd0) ? 16'd1 : cmd_off_ms;
                    done_nxt_s    = (cmd_count == 8'd0);
                end else begin
                    done_nxt_s    = 1'b0;
                end
            end
            ST_ON, ST_OFF: begin
                if (abort) begin
                    presc_nxt_s   = {PW{1'b0}};
                    phase_nxt_s   = 16'd0;
                    blinks_nxt_s  = 8'd0;
                    aborted_nxt_s = 1'b1;
                end else begin
                    if (tick_s) begin
                        presc_nxt_s = {PW{1'b0}};
                    end else begin
                        presc_nxt_s = presc_r + PRESC_ONE;
                    end
                    if (phase_end_s) begin
                        phase_nxt_s = 16'd0;
                        // Blinks count down only once the off phase has fully elapsed.
                        if (state_r == ST_OFF) begin
                            blinks_nxt_s = blinks_left_r - 8'd1;
                            done_nxt_s   = last_blink_s;
                        end else begin
                            blinks_nxt_s = blinks_left_r;
                        end
                    end else if (tick_s) begin
                        phase_nxt_s = phase_r + 16'd1;
                    end else begin
                        phase_nxt_s = phase_r;
                    end
                end
            end
            default: begin
                presc_nxt_s  = {PW{1'b0}};
                phase_nxt_s  = 16'd0;
                blinks_nxt_s = 8'd0;
            end
        endcase
    end

    // Datapath and output registers; cmd_ready stays low until the first edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r       <= {PW{1'b0}};
            phase_r       <= 16'd0;
            on_dur_r      <= 16'd1;
            off_dur_r     <= 16'd1;
            blinks_left_r <= 8'd0;
            led_r         <= 1'b0;
            busy_r        <= 1'b0;
            ready_r       <= 1'b0;
            done_r        <= 1'b0;
            aborted_r     <= 1'b0;
        end else begin
            presc_r       <= presc_nxt_s;
            phase_r       <= phase_nxt_s;
            on_dur_r      <= on_dur_nxt_s;
            off_dur_r     <= off_dur_nxt_s;
            blinks_left_r <= blinks_nxt_s;
            led_r         <= led_nxt_s;
            busy_r        <= busy_nxt_s;
            ready_r       <= ready_nxt_s;
            done_r        <= done_nxt_s;
            aborted_r     <= aborted_nxt_s;
        end
    end

    assign cmd_ready   = ready_r;
    assign led         = led_r;
    assign busy        = busy_r;
    assign blinks_left = blinks_left_r;
    assign done        = done_r;
    assign aborted     = aborted_r;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each
// cycle against a timeline model derived from the blink timing rules.
module tb_led_blink_sequencer;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_count;
    logic [15:0] cmd_on_ms;
    logic [15:0] cmd_off_ms;
    logic        abort;
    logic        led;
    logic        busy;
    logic [7:0]  blinks_left;
    logic        done;
    logic        aborted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    int done_at = -1;
    int ab_at = -1;
    int rst_hold = 0;
    logic s_led, s_ready;

    // Reference model: command timeline measured in cycles since acceptance.
    bit m_busy, m_ready, m_done_now, m_ab_now;
    int m_k, m_count, m_on, m_off;

    led_blink_sequencer #(.CLK_FREQ_KHz(1), .TICK_FREQ_Hz(250)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_count(cmd_count), .cmd_on_ms(cmd_on_ms), .cmd_off_ms(cmd_off_ms),
        .abort(abort), .led(led), .busy(busy), .blinks_left(blinks_left),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ready = 1'b0; m_done_now = 1'b0; m_ab_now = 1'b0;
    endtask

    task automatic check_outputs();
        int period, idx, r, e_led, e_busy, e_ready, e_bl;
        if (m_busy) begin
            period  = (m_on + m_off) * TICK_DIV;
            idx     = (m_k - 1) / period;
            r       = (m_k - 1) % period;
            e_led   = (r < m_on * TICK_DIV) ? 1 : 0;
            e_busy  = 1;
            e_ready = 0;
            e_bl    = m_count - idx;
        end else begin
            e_led   = 0;
            e_busy  = 0;
            e_ready = m_ready ? 1 : 0;
            e_bl    = 0;
        end
        check("led", 32'(led), 32'(e_led));
        check("busy", 32'(busy), 32'(e_busy));
        check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        check("blinks_left", 32'(blinks_left), 32'(e_bl));
        check("done", 32'(done), 32'(m_done_now));
        check("aborted", 32'(aborted), 32'(m_ab_now));
    endtask

    task automatic model_edge();
        int period;
        m_done_now = 1'b0;
        m_ab_now   = 1'b0;
        if (!rst) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
        end else begin
            if (!m_busy) begin
                if (m_ready && cmd_valid) begin
                    if (cmd_count == 8'd0) begin
                        m_done_now = 1'b1;
                    end else begin
                        m_busy  = 1'b1;
                        m_k     = 1;
                        m_count = int'(cmd_count);
                        m_on    = (cmd_on_ms == 16'd0) ? 1 : int'(cmd_on_ms);
                        m_off   = (cmd_off_ms == 16'd0) ? 1 : int'(cmd_off_ms);
                    end
                end
            end else begin
                period = (m_on + m_off) * TICK_DIV;
                if (abort) begin
                    m_busy   = 1'b0;
                    m_ab_now = 1'b1;
                end else if (m_k == m_count * period) begin
                    m_busy     = 1'b0;
                    m_done_now = 1'b1;
                end else begin
                    m_k++;
                end
            end
            m_ready = 1'b1;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        s_led   = led;
        s_ready = cmd_ready;
        if (done === 1'b1 && done_at < 0) done_at = cyc;
        if (aborted === 1'b1 && ab_at < 0) ab_at = cyc;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int cnt, input int on, input int off);
        cmd_valid  = 1'b1;
        cmd_count  = 8'(cnt);
        cmd_on_ms  = 16'(on);
        cmd_off_ms = 16'(off);
        c0 = cyc; done_at = -1; ab_at = -1;
        run_cycle();
        cmd_valid  = 1'b0;
        cmd_count  = 8'($urandom_range(0, 255));
        cmd_on_ms  = 16'($urandom_range(0, 9));
        cmd_off_ms = 16'($urandom_range(0, 9));
    endtask

    task automatic check_async_reset();
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_blinks", 32'(blinks_left), 32'd0);
        model_reset();
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_count = 8'd0;
        cmd_on_ms = 16'd0; cmd_off_ms = 16'd0; abort = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check("init_ready_low", 32'(s_ready), 32'd0);
        run_cycle();
        check("init_ready_high", 32'(s_ready), 32'd1);

        // Basic two-blink command
        issue(2, 1, 2);
        repeat (26) run_cycle();
        check("basic_done_cycle", 32'(done_at - c0), 32'd25);
        check("basic_no_abort", 32'(ab_at), 32'hFFFF_FFFF);

        // Zero-count command completes immediately
        issue(0, 5, 5);
        repeat (3) run_cycle();
        check("zero_done_cycle", 32'(done_at - c0), 32'd1);

        // Zero durations behave as one tick
        issue(3, 0, 0);
        repeat (26) run_cycle();
        check("zdur_done_cycle", 32'(done_at - c0), 32'd25);

        // Abort during cycle 6
        issue(2, 1, 2);
        for (int i = 1; i <= 26; i++) begin
            abort = (i == 6);
            run_cycle();
        end
        abort = 1'b0;
        check("abort_cycle", 32'(ab_at - c0), 32'd7);
        check("abort_no_done", 32'(done_at), 32'hFFFF_FFFF);

        // Back-to-back with cmd_valid held high and fields changing mid-command
        cmd_valid = 1'b1; cmd_count = 8'd1; cmd_on_ms = 16'd1; cmd_off_ms = 16'd1;
        c0 = cyc; done_at = -1; ab_at = -1;
        run_cycle();
        cmd_count = 8'd2; cmd_on_ms = 16'd2; cmd_off_ms = 16'd1;
        for (int i = 1; i <= 9; i++) run_cycle();
        check("b2b_done_cycle", 32'(done_at - c0), 32'd9);
        run_cycle();
        check("b2b_led", 32'(s_led), 32'd1);
        cmd_valid = 1'b0;
        repeat (30) run_cycle();

        // Asynchronous reset mid-ON
        issue(2, 1, 2);
        repeat (2) run_cycle();
        rst = 1'b0;
        check_async_reset();
        run_cycle();
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check("rel_ready_low", 32'(s_ready), 32'd0);
        run_cycle();
        check("rel_ready_high", 32'(s_ready), 32'd1);
        check("rst_no_done", 32'(done_at), 32'hFFFF_FFFF);
        check("rst_no_abort", 32'(ab_at), 32'hFFFF_FFFF);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_count  = 8'($urandom_range(0, 4));
            cmd_on_ms  = 16'($urandom_range(0, 4));
            cmd_off_ms = 16'($urandom_range(0, 4));
            abort      = ($urandom_range(0, 59) == 0);
            if (rst && ($urandom_range(0, 399) == 0)) begin
                rst = 1'b0;
                check_async_reset();
                rst_hold = $urandom_range(1, 3);
            end else if (!rst) begin
                rst_hold--;
                if (rst_hold <= 0) rst = 1'b1;
            end
            run_cycle();
        end
        rst = 1'b1;
        abort = 1'b0;
        cmd_valid = 1'b0;
        repeat (200) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
LED_BLINK_SEQUENCER -- requirements
Module: led_blink_sequencer

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_KHz, default 50000, meaning the clock frequency in kHz.
REQ-002 The module SHALL have parameter TICK_FREQ_Hz, default 1000, meaning the duration-unit tick rate (1 ms).
REQ-003 TICK_DIV SHALL equal (CLK_FREQ_KHz*1000)/TICK_FREQ_Hz; TICK_DIV >= 1 and exact division are required, and any other value is a configuration error.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port cmd_valid, input, 1 bit: a command is presented.
REQ-007 Port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 Port cmd_count, input, 8 bits: number of blinks to perform.
REQ-009 Port cmd_on_ms, input, 16 bits: LED-on duration in ticks.
REQ-010 Port cmd_off_ms, input, 16 bits: LED-off duration in ticks.
REQ-011 Port abort, input, 1 bit: cancels the running command.
REQ-012 Port led, output, 1 bit: the LED drive, active-high.
REQ-013 Port busy, output, 1 bit: a command is executing.
REQ-014 Port blinks_left, output, 8 bits: remaining blinks, including the current blink.
REQ-015 Port done, output, 1 bit: single-cycle pulse on normal completion.
REQ-016 Port aborted, output, 1 bit: single-cycle pulse on abort.

Function
REQ-017 The FSM SHALL have states IDLE, ON and OFF; led SHALL be 1 only in ON; busy SHALL be 1 in ON or OFF; cmd_ready SHALL be 1 only in IDLE.
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_count, cmd_on_ms and cmd_off_ms SHALL be latched at that edge, and later changes to these inputs SHALL be ignored.
REQ-019 An on or off duration of 0 SHALL be treated as 1.
REQ-020 On acceptance with cmd_count>0, the FSM SHALL go IDLE->ON, so that led=1 in the first cycle after the accept edge; the prescaler and phase counter SHALL clear.
REQ-021 On acceptance with cmd_count=0, the FSM SHALL stay in IDLE, done SHALL be 1 in the next cycle, and led SHALL stay 0.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 and wrap, and SHALL produce a tick when its count equals TICK_DIV-1; it SHALL run only in ON or OFF; its width SHALL be max(1, clog2(TICK_DIV)).
REQ-023 The ON phase SHALL last exactly on*TICK_DIV clock cycles, then transition to OFF; the OFF phase SHALL last exactly off*TICK_DIV cycles.
REQ-024 At the end of OFF, blinks_left SHALL decrement; if the result is nonzero, the FSM SHALL return to ON, with no gap cycle; if the result is 0, the FSM SHALL go to IDLE with done=1 for exactly that first IDLE cycle.
REQ-025 The final OFF phase SHALL always be executed; total command time SHALL be count*(on+off)*TICK_DIV cycles.
REQ-026 A new command SHALL be acceptable in the same cycle that done=1 (back-to-back operation).
REQ-027 blinks_left SHALL load cmd_count at accept and SHALL be 0 in IDLE after completion or abort.
REQ-028 abort=1 sampled in ON or OFF SHALL force IDLE at that edge: in the next cycle led=0, busy=0, aborted=1 for one cycle, and done SHALL not pulse.
REQ-029 abort in IDLE SHALL be ignored; if abort and an accept occur in the same IDLE cycle, the command SHALL be accepted.
REQ-030 done and aborted SHALL never be 1 in the same cycle.

Reset
REQ-031 rst=0 SHALL immediately, without a clock edge, force state IDLE, led=0, busy=0, done=0, aborted=0, blinks_left=0, and clear the prescaler and phase counter.
REQ-032 While rst=0, cmd_ready SHALL be 0; cmd_ready SHALL become 1 in the first cycle after rst=1 is sampled.
REQ-033 Reset asserted mid-command SHALL discard the command; no done or aborted pulse SHALL be generated.

Verification (bench parameters: CLK_FREQ_KHz=1, TICK_FREQ_Hz=250, giving TICK_DIV=4; accept edge ends cycle 0)
REQ-034 Stimulus count=2, on=1, off=2 -> led=1 in cycles 1-4 and 13-16, led=0 in cycles 5-12 and 17-24, blinks_left=2 then 1, done=1 only in cycle 25 with cmd_ready=1.
REQ-035 Stimulus count=0 -> done=1 in cycle 1, led=0 and busy=0 throughout, cmd_ready stays 1.
REQ-036 Stimulus count=3, on=0, off=0 -> led alternates 4 cycles high and 4 cycles low, three times; done in cycle 25.
REQ-037 Stimulus: the scenario of REQ-034 with abort=1 during cycle 6 -> cycle 7: led=0, busy=0, aborted=1, blinks_left=0; done never pulses.
REQ-038 Stimulus: cmd_valid held high during a command with new fields -> no accept while busy; the command is accepted in the done cycle, and led=1 in the following cycle.
REQ-039 Stimulus: rst driven low mid-ON between clock edges -> led=0 and busy=0 before the next edge; cmd_ready=0 until the cycle after rst=1 is sampled; no pulses are generated.
